// File: rtl/clock_divider.sv
// clock_divider: divides ClkOsc by N = InputClkFreq/OutputClkFreq into a
// registered, near-50%-duty ClkDiv.
//
// Ports:
//   ClkOsc  in   input clock; all state updates on its rising edge
//   Rst     in   asynchronous active-low reset (clears counter and ClkDiv)
//   ClkDiv  out  divided clock, driven directly from a flop
//
// Timing from reset release: low for L = N/2 edges, high for H = N-L edges,
// period N.  Odd N gives the extra cycle to the high phase.
module clock_divider #(
    parameter int InputClkFreq  = 50_000_000,
    parameter int OutputClkFreq = 100
) (
    input  logic ClkOsc,
    input  logic Rst,
    output logic ClkDiv
);

    // A zero/negative output frequency is rejected below; the fallback of 2
    // only keeps the derived widths legal while that error is reported.
    localparam int N  = (OutputClkFreq > 0) ? InputClkFreq / OutputClkFreq : 2;
    localparam int L  = N / 2;
    localparam int H  = N - L;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] RISE = CW'(L - 1);

    generate
        if (OutputClkFreq <= 0) begin : g_bad_out
            $error("clock_divider: OutputClkFreq must be positive");
        end else if (N < 2) begin : g_bad_ratio
            $error("clock_divider: ratio below 2, OutputClkFreq too high");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // cnt walks 0..N-1 and wraps; ClkDiv rises after the L-th edge of a
    // period (cnt==L-1) and falls on the N-th (cnt==N-1).  For N=2 these
    // two points are adjacent, so ClkDiv toggles every edge.
    always_ff @(posedge ClkOsc or negedge Rst) begin
        if (!Rst) begin
            cnt    <= '0;
            ClkDiv <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == RISE) begin
                ClkDiv <= 1'b1;
            end else if (cnt == LAST) begin
                ClkDiv <= 1'b0;
            end
        end
    end

    // H is kept as a named quantity of the timing contract; it is implied
    // by the RISE/LAST compare points above.
    logic unused_h;
    assign unused_h = (H > 0);

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: four divider instances (N=4,5,2 and truncated 7) under
// random asynchronous resets, checked against an edge-count model.
module tb_clock_divider;

    logic       clk;
    logic [3:0] rst_n;
    logic [3:0] div;

    clock_divider #(.InputClkFreq(8),  .OutputClkFreq(2)) u_n4 (
        .ClkOsc(clk), .Rst(rst_n[0]), .ClkDiv(div[0]));
    clock_divider #(.InputClkFreq(10), .OutputClkFreq(2)) u_n5 (
        .ClkOsc(clk), .Rst(rst_n[1]), .ClkDiv(div[1]));
    clock_divider #(.InputClkFreq(2),  .OutputClkFreq(1)) u_n2 (
        .ClkOsc(clk), .Rst(rst_n[2]), .ClkDiv(div[2]));
    clock_divider #(.InputClkFreq(15), .OutputClkFreq(2)) u_n7 (
        .ClkOsc(clk), .Rst(rst_n[3]), .ClkDiv(div[3]));

    // Ratios as the reference sees them: integer division, truncated.
    int nn [4] = '{8 / 2, 10 / 2, 2 / 1, 15 / 2};

    typedef struct {
        int idx;
        bit exp;
        bit mid;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    e    [4];
    int    hold [4];
    bit    forced = 0;
    bit    saw_forced = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: after the k-th counted edge since release, ClkDiv is high
    // exactly when (k mod N) lies in the upper H slots [N/2, N).
    function automatic bit model(int i);
        if (!rst_n[i]) return 1'b0;
        return (e[i] % nn[i]) >= (nn[i] / 2);
    endfunction

    task automatic push_all(bit mid);
        for (int i = 0; i < 4; i++) begin
            item_t it;
            it.idx = i;
            it.exp = model(i);
            it.mid = mid;
            q.push_back(it);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            checks++;
            if (div[it.idx] !== it.exp) begin
                errors++;
                $display("FAIL div_n%0d %s t=%0t got %b expected %b",
                         nn[it.idx], it.mid ? "mid" : "edge", $time,
                         div[it.idx], it.exp);
            end
        end
    endtask

    // Monitor: compares whatever the driver has queued, once just after
    // each edge and once after the mid-cycle reset activity.
    initial begin
        forever begin
            @(posedge clk);
            #2 drain();
            #4 drain();
        end
    end

    initial begin
        rst_n = '0;
        for (int i = 0; i < 4; i++) begin
            e[i]    = 0;
            hold[i] = 4;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rst_n[i]) e[i]++;
            end
            #1 push_all(1'b0);
            #3;
            for (int i = 0; i < 4; i++) begin
                forced = (i == 0) && (c >= 200) && !saw_forced
                         && rst_n[0] && (e[0] % 4 == 3);
                if (!rst_n[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else rst_n[i] = 1'b1;
                end else if (forced || $urandom_range(0, 39) == 0) begin
                    if (forced) saw_forced = 1'b1;
                    rst_n[i] = 1'b0;
                    e[i]     = 0;
                    hold[i]  = $urandom_range(0, 2);
                end
            end
            #1 push_all(1'b1);
        end
        @(posedge clk);
        #8;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left %0d expected 0", q.size());
        end
        checks++;
        if (!saw_forced) begin
            errors++;
            $display("FAIL high_phase_reset hit %b expected 1", saw_forced);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
